// File: rtl/bfm_apb_pkg.sv
// bfm_apb_pkg: shared types and widths for the APB slave RAM BFM
package bfm_apb_pkg;
    typedef enum logic {IDLE, ACCESS} state_e;
    localparam int APB_DW = 32;
    localparam int WAIT_W = 4;
    localparam int CNT_W = 16;
endpackage

// File: rtl/apb_slave_ram_array.sv
// apb_slave_ram_array: single-port word RAM, synchronous write, registered read, zero at time 0
module apb_slave_ram_array
    import bfm_apb_pkg::*;
#(
    parameter int AWIDTH = 10,
    parameter int DEPTH = 1024
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AWIDTH-1:0] addr,
    input  logic [APB_DW-1:0] wdata,
    output logic [APB_DW-1:0] rdata
);
    logic [APB_DW-1:0] mem [DEPTH] = '{default: '0};
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/apb_slave_ram_bfm.sv
// apb_slave_ram_bfm: APB3 RAM slave with wait states, error injection,
// protocol-violation flag and completed-transfer counters
module apb_slave_ram_bfm
    import bfm_apb_pkg::*;
#(
    parameter int AWIDTH = 10,
    parameter int DEPTH = 1024,
    parameter int TPD = 1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic [APB_DW-1:0] PADDR,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [APB_DW-1:0] PWDATA,
    output logic [APB_DW-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [WAIT_W-1:0] WAIT_CYCLES,
    input  logic              ERR_INJECT,
    output logic              PROT_ERR,
    output logic [CNT_W-1:0]  WR_COUNT,
    output logic [CNT_W-1:0]  RD_COUNT
);
    if (DEPTH > (1 << AWIDTH) || TPD < 0) begin : g_bad_params
        $error("apb_slave_ram_bfm: DEPTH exceeds decoded window or negative TPD");
    end

    state_e state, state_nx;
    logic [APB_DW-1:0] addr_q, wdata_q, ram_q;
    logic [WAIT_W-1:0] cnt;
    logic wr_q, err_q, rdy;
    logic [AWIDTH-1:0] p_idx;
    logic p_err, setup, complete, abort, no_setup, changed;

    assign p_idx = PADDR[AWIDTH+1:2];
    assign p_err = ERR_INJECT || PADDR[APB_DW-1:AWIDTH+2] != '0 || int'(p_idx) >= DEPTH;
    assign setup = state == IDLE && PSEL && !PENABLE;
    assign no_setup = state == IDLE && PSEL && PENABLE;
    assign complete = state == ACCESS && rdy && PSEL && PENABLE;
    assign abort = state == ACCESS && !PSEL;
    assign changed = state == ACCESS && PSEL && (PADDR != addr_q || PWRITE != wr_q || PWDATA != wdata_q);

    always_comb begin
        state_nx = state;
        state_nx = setup ? ACCESS : (complete || abort) ? IDLE : state;
    end

    // RAM is addressed by the live bus in setup and by the latched index afterwards
    apb_slave_ram_array #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) u_ram (
        .clk   (PCLK),
        .we    (complete && wr_q && !err_q && !PRESET),
        .re    (setup && !PWRITE && !p_err),
        .addr  (state == ACCESS ? addr_q[AWIDTH+1:2] : p_idx),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
            rdy <= 1'b0;
            err_q <= 1'b0;
            wr_q <= 1'b0;
            cnt <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            PROT_ERR <= 1'b0;
            WR_COUNT <= '0;
            RD_COUNT <= '0;
        end else begin
            state <= state_nx;
            if (setup) begin
                addr_q <= PADDR;
                wr_q <= PWRITE;
                wdata_q <= PWDATA;
                err_q <= p_err;
                cnt <= WAIT_CYCLES;
                rdy <= WAIT_CYCLES == '0;
            end else if (complete || abort) begin
                rdy <= 1'b0;
            end else if (state == ACCESS && !rdy) begin
                cnt <= cnt - WAIT_W'(1);
                rdy <= cnt == WAIT_W'(1);
            end
            if (no_setup || abort || changed) PROT_ERR <= 1'b1;
            if (complete && !err_q && wr_q) WR_COUNT <= WR_COUNT + CNT_W'(1);
            if (complete && !err_q && !wr_q) RD_COUNT <= RD_COUNT + CNT_W'(1);
        end
    end

    assign PREADY = state == ACCESS && rdy;
    assign PSLVERR = PREADY && err_q;
    assign PRDATA = (PREADY && !wr_q && !err_q) ? ram_q : '0;
endmodule

// File: tb/tb_apb_slave_ram_bfm.sv
// tb_apb_slave_ram_bfm: directed plan plus random transfers against a word-array model
module tb_apb_slave_ram_bfm;
    logic PCLK = 1'b0;
    logic PRESET, PSEL, PENABLE, PWRITE, ERR_INJECT;
    logic PREADY, PSLVERR, PROT_ERR;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0] WAIT_CYCLES;
    logic [15:0] WR_COUNT, RD_COUNT;
    int checks = 0, errors = 0;
    logic [31:0] ref_mem [1024];
    int ref_wr = 0, ref_rd = 0;
    bit ref_prot = 0;

    always #5 PCLK = ~PCLK;

    apb_slave_ram_bfm dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .WAIT_CYCLES(WAIT_CYCLES), .ERR_INJECT(ERR_INJECT),
        .PROT_ERR(PROT_ERR), .WR_COUNT(WR_COUNT), .RD_COUNT(RD_COUNT)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_status(string tag);
        check({tag, "_wr_count"}, WR_COUNT, 32'(ref_wr[15:0]));
        check({tag, "_rd_count"}, RD_COUNT, 32'(ref_rd[15:0]));
        check({tag, "_prot_err"}, PROT_ERR, ref_prot);
    endtask

    task automatic do_reset();
        PRESET = 1; PSEL = 0; PENABLE = 0;
        @(posedge PCLK); #1;
        PRESET = 0;
        ref_wr = 0; ref_rd = 0; ref_prot = 0;
        check("rst_pready", PREADY, 0);
        check("rst_pslverr", PSLVERR, 0);
        check("rst_prdata", PRDATA, 0);
        check_status("rst");
    endtask

    // One full transfer; caller's time is just after a rising edge
    task automatic xfer(bit wr, logic [31:0] addr, logic [31:0] data, int waits, bit inj, bit glitch);
        bit exp_err = inj || (addr >> 2) >= 1024;
        int idx = int'(addr[11:2]);
        int seen = 0;
        logic [31:0] exp_rd = (wr || exp_err) ? 32'h0 : ref_mem[idx];
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = data;
        WAIT_CYCLES = 4'(waits); ERR_INJECT = inj;
        @(posedge PCLK); #1;
        PENABLE = 1;
        WAIT_CYCLES = 4'($urandom);
        ERR_INJECT = 1'($urandom);
        if (glitch) PWDATA = ~data;
        while (1) begin
            @(negedge PCLK);
            if (PREADY) break;
            check("prdata_during_wait", PRDATA, 0);
            check("pslverr_during_wait", PSLVERR, 0);
            seen++;
            if (seen > 20) break;
            @(posedge PCLK); #1;
        end
        check("wait_states", seen, waits);
        check("pslverr", PSLVERR, exp_err);
        check("prdata", PRDATA, exp_rd);
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
        if (glitch) ref_prot = 1;
        if (!exp_err && wr) begin ref_mem[idx] = data; ref_wr++; end
        if (!exp_err && !wr) ref_rd++;
        check("pready_after", PREADY, 0);
        check_status("xfer");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 0;
        PADDR = 0; PWDATA = 0; PWRITE = 0; WAIT_CYCLES = 0; ERR_INJECT = 0;
        PRESET = 1; PSEL = 0; PENABLE = 0;
        repeat (2) @(posedge PCLK);
        #1 do_reset();

        xfer(1, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        xfer(0, 32'h10, 32'h0, 0, 0, 0);
        xfer(0, 32'h10, 32'h0, 3, 0, 0);
        xfer(1, 32'h1000, 32'hAAAA5555, 0, 0, 0);
        xfer(0, 32'h1000, 32'h0, 0, 0, 0);
        xfer(1, 32'h20, 32'h12345678, 1, 1, 0);
        xfer(0, 32'h20, 32'h0, 0, 0, 0);

        // abort: PSEL drops during the wait phase of a write
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h30; PWDATA = 32'hCAFEF00D;
        WAIT_CYCLES = 2; ERR_INJECT = 0;
        @(posedge PCLK); #1 PENABLE = 1;
        @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
        @(posedge PCLK); #1;
        ref_prot = 1;
        check("abort_pready", PREADY, 0);
        check_status("abort");
        xfer(0, 32'h30, 32'h0, 0, 0, 0);
        do_reset();
        xfer(0, 32'h10, 32'h0, 1, 0, 0);

        // access phase without setup while idle
        PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = 32'h40; PWDATA = 32'h1;
        @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
        ref_prot = 1;
        check_status("no_setup");
        check("no_setup_pready", PREADY, 0);
        do_reset();

        // bus change during access: flagged, latched values still used
        xfer(0, 32'h10, 32'h5, 2, 0, 1);
        do_reset();

        xfer(1, 32'h0, 32'h11111111, 0, 0, 0);
        xfer(1, 32'h4, 32'h22222222, 0, 0, 0);
        xfer(1, 32'h8, 32'h33333333, 0, 0, 0);
        xfer(0, 32'h0, 32'h0, 0, 0, 0);
        xfer(0, 32'h4, 32'h0, 0, 0, 0);
        xfer(0, 32'h8, 32'h0, 0, 0, 0);
        check("b2b_wr_total", WR_COUNT, 3);
        check("b2b_rd_total", RD_COUNT, 3);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? (32'h1000 + ($urandom & 32'hFFFC)) : 32'($urandom_range(0, 15)) << 2;
            xfer(1'($urandom), a, $urandom, $urandom_range(0, 4), $urandom_range(0, 7) == 0, 0);
            if ($urandom_range(0, 3) == 0) begin @(posedge PCLK); #1; end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
